// File: rtl/audio_scheduler_pkg.sv
// Shared game package: presente encodings, track IDs, audio FSM states
// and the small decode helpers used by the audio scheduler.
package audio_scheduler_pkg;

    typedef enum logic [3:0] {
        PRES_APAGADO   = 4'd0,
        PRES_HOLA      = 4'd1,
        PRES_PERSONAJE = 4'd2,
        PRES_JUEGO     = 4'd3,
        PRES_GP        = 4'd4,
        PRES_YN        = 4'd5
    } presente_e;

    typedef enum logic [2:0] {
        TRK_NONE  = 3'd0,
        TRK_INTRO = 3'd1,
        TRK_GAME  = 3'd2,
        TRK_WIN   = 3'd3,
        TRK_LOSE  = 3'd4
    } track_e;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_GAP    = 2'd1,
        ST_PLAY   = 2'd2,
        ST_SFX    = 2'd3
    } aud_state_e;

    localparam logic [1:0] VD_DEFEAT  = 2'd1;
    localparam logic [1:0] VD_VICTORY = 2'd2;

    // Track that the current game state wants to hear.
    function automatic track_e target_track(input logic [3:0] presente,
                                            input logic [1:0] v_d);
        track_e t;
        t = TRK_NONE;
        case (presente)
            PRES_HOLA, PRES_PERSONAJE: t = TRK_INTRO;
            PRES_JUEGO:                t = TRK_GAME;
            PRES_GP: begin
                if (v_d == VD_VICTORY)     t = TRK_WIN;
                else if (v_d == VD_DEFEAT) t = TRK_LOSE;
            end
            default:                   t = TRK_NONE;
        endcase
        return t;
    endfunction

    // Index of the highest set request bit (bit2 has highest priority).
    function automatic logic [1:0] sfx_top(input logic [2:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        if (req[2])      idx = 2'd2;
        else if (req[1]) idx = 2'd1;
        return idx;
    endfunction

endpackage

// File: rtl/audio_scheduler_ms_tick.sv
// Millisecond timebase: one-cycle tick every CLK_HZ/1000 cycles,
// realigned to zero whenever restart is asserted.
module audio_ms_tick #(
    parameter int unsigned CLK_HZ = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / 1000;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Cycle counter wrapping at DIV-1; restart forces a fresh ms period.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_scheduler.sv
// Audio scheduler: picks the background track for the game state,
// inserts a silence gap before each new track and overlays short
// prioritised sound effects on top of the playing track.
module audio_scheduler #(
    parameter int unsigned CLK_HZ = 25000000,
    parameter int unsigned GAP_MS = 50,
    parameter int unsigned SFX_MS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] presente,
    input  logic [1:0] v_d,
    input  logic [2:0] sfx_req,
    input  logic [3:0] muic,
    input  logic [2:0] sfx_tone,
    output logic [2:0] track_sel,
    output logic       play_en,
    output logic       sfx_en,
    output logic [1:0] sfx_sel,
    output logic       musica
);

    import audio_scheduler_pkg::*;

    localparam int unsigned MS_MAX = (GAP_MS > SFX_MS) ? GAP_MS : SFX_MS;
    localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

    aud_state_e      state, state_n;
    track_e          track_q, track_n, target;
    logic [1:0]      sel_n;
    logic [MS_W-1:0] ms_cnt, ms_n;
    logic            restart, tick, musica_n;

    assign track_sel = track_q;

    audio_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // Next-state decode; restart marks every state entry or timing reload.
    always_comb begin
        target   = target_track(presente, v_d);
        state_n  = state;
        track_n  = track_q;
        sel_n    = sfx_sel;
        restart  = 1'b0;
        musica_n = 1'b0;
        case (state)
            ST_SILENT: begin
                if (target != TRK_NONE) begin
                    state_n = ST_GAP;
                    track_n = target;
                    restart = 1'b1;
                end
            end
            ST_GAP: begin
                if (target == TRK_NONE) begin
                    state_n = ST_SILENT;
                    track_n = TRK_NONE;
                    restart = 1'b1;
                end else if (target != track_q) begin
                    track_n = target;
                    restart = 1'b1;
                end else if (tick && ms_cnt == MS_W'(GAP_MS - 1)) begin
                    state_n = ST_PLAY;
                    restart = 1'b1;
                end
            end
            ST_PLAY: begin
                musica_n = muic[2'(track_q - 3'd1)];
                // Track change outranks a same-cycle effect request.
                if (target != track_q) begin
                    state_n = (target == TRK_NONE) ? ST_SILENT : ST_GAP;
                    track_n = target;
                    restart = 1'b1;
                end else if (sfx_req != '0) begin
                    state_n = ST_SFX;
                    sel_n   = sfx_top(sfx_req);
                    restart = 1'b1;
                end
            end
            ST_SFX: begin
                musica_n = sfx_tone[sfx_sel];
                if (target != track_q) begin
                    state_n = (target == TRK_NONE) ? ST_SILENT : ST_GAP;
                    track_n = target;
                    restart = 1'b1;
                end else if (sfx_req != '0 && sfx_top(sfx_req) > sfx_sel) begin
                    sel_n   = sfx_top(sfx_req);
                    restart = 1'b1;
                end else if (tick && ms_cnt == MS_W'(SFX_MS - 1)) begin
                    state_n = ST_PLAY;
                    restart = 1'b1;
                end
            end
            default: begin
                state_n = ST_SILENT;
                track_n = TRK_NONE;
                restart = 1'b1;
            end
        endcase
        if (restart)   ms_n = '0;
        else if (tick) ms_n = ms_cnt + 1'b1;
        else           ms_n = ms_cnt;
    end

    // State, ms count and all outputs registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_SILENT;
            track_q <= TRK_NONE;
            sfx_sel <= '0;
            ms_cnt  <= '0;
            play_en <= 1'b0;
            sfx_en  <= 1'b0;
            musica  <= 1'b0;
        end else begin
            state   <= state_n;
            track_q <= track_n;
            sfx_sel <= sel_n;
            ms_cnt  <= ms_n;
            play_en <= (state_n == ST_PLAY) || (state_n == ST_SFX);
            sfx_en  <= (state_n == ST_SFX);
            musica  <= musica_n;
        end
    end

endmodule

// File: tb/tb_audio_scheduler.sv
// Bench for audio_scheduler with 1 ms = 1 cycle, 3 ms gap, 5 ms effect.
module tb_audio_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] presente;
    logic [1:0] v_d;
    logic [2:0] sfx_req;
    logic [3:0] muic;
    logic [2:0] sfx_tone;
    logic [2:0] track_sel;
    logic       play_en;
    logic       sfx_en;
    logic [1:0] sfx_sel;
    logic       musica;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_scheduler #(.CLK_HZ(1000), .GAP_MS(3), .SFX_MS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .presente (presente),
        .v_d      (v_d),
        .sfx_req  (sfx_req),
        .muic     (muic),
        .sfx_tone (sfx_tone),
        .track_sel(track_sel),
        .play_en  (play_en),
        .sfx_en   (sfx_en),
        .sfx_sel  (sfx_sel),
        .musica   (musica)
    );

    typedef struct {
        logic       rst;
        logic [3:0] pres;
        logic [1:0] vd;
        logic [2:0] req;
        logic [3:0] mu;
        logic [2:0] tone;
        logic [2:0] trk;
        logic       pe;
        logic       se;
        logic [1:0] sel;
        logic       mus;
    } vec_t;

    typedef struct {
        int         row;
        logic [2:0] trk;
        logic       pe;
        logic       se;
        logic [1:0] sel;
        logic       mus;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic rst, input int pres, input int vd, input int req,
                       input int mu, input int tone, input int trk, input int pe,
                       input int se, input int sel, input int mus);
        vec_t v;
        v.rst = rst; v.pres = 4'(pres); v.vd = 2'(vd); v.req = 3'(req);
        v.mu = 4'(mu); v.tone = 3'(tone); v.trk = 3'(trk); v.pe = 1'(pe);
        v.se = 1'(se); v.sel = 2'(sel); v.mus = 1'(mus);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, req_v);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk("track_sel", e.row, int'(track_sel), int'(e.trk));
        chk("play_en",   e.row, int'(play_en),   int'(e.pe));
        chk("sfx_en",    e.row, int'(sfx_en),    int'(e.se));
        chk("sfx_sel",   e.row, int'(sfx_sel),   int'(e.sel));
        chk("musica",    e.row, int'(musica),    int'(e.mus));
    endtask

    initial begin
        exp_t e;
        int   edges;
        reset = 1'b1; presente = '0; v_d = '0; sfx_req = '0; muic = '0; sfx_tone = '0;

        //   rst pres vd req mu tone | trk pe se sel mus  (outputs after the edge)
        add(1, 0, 0, 0, 15, 7,  0, 0, 0, 0, 0);  // 0 reset
        add(0, 1, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 1 SILENT -> GAP intro
        add(0, 1, 0, 0, 15, 0,  1, 0, 0, 0, 0);  // 2 gap, muic muted
        add(0, 1, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 3
        add(0, 1, 0, 0, 0,  0,  1, 1, 0, 0, 0);  // 4 PLAY
        add(0, 1, 0, 0, 1,  0,  1, 1, 0, 0, 1);  // 5 musica = muic[0]
        add(0, 1, 0, 0, 14, 0,  1, 1, 0, 0, 0);  // 6 other notes ignored
        add(0, 3, 0, 0, 1,  0,  2, 0, 0, 0, 1);  // 7 -> GAP game
        add(0, 3, 0, 0, 0,  0,  2, 0, 0, 0, 0);  // 8
        add(0, 3, 0, 0, 0,  0,  2, 0, 0, 0, 0);  // 9
        add(0, 3, 0, 0, 0,  0,  2, 1, 0, 0, 0);  // 10 PLAY
        add(0, 3, 0, 0, 2,  0,  2, 1, 0, 0, 1);  // 11 muic[1]
        add(0, 4, 2, 0, 2,  0,  3, 0, 0, 0, 1);  // 12 -> GAP win
        add(0, 4, 2, 0, 0,  0,  3, 0, 0, 0, 0);  // 13
        add(0, 4, 1, 0, 0,  0,  4, 0, 0, 0, 0);  // 14 retarget lose, gap restarts
        add(0, 4, 1, 0, 0,  0,  4, 0, 0, 0, 0);  // 15
        add(0, 4, 1, 7, 0,  0,  4, 0, 0, 0, 0);  // 16 sfx ignored in GAP
        add(0, 4, 1, 0, 0,  0,  4, 1, 0, 0, 0);  // 17 PLAY
        add(0, 4, 1, 0, 8,  0,  4, 1, 0, 0, 1);  // 18 muic[3]
        add(0, 4, 1, 0, 7,  0,  4, 1, 0, 0, 0);  // 19
        add(0, 4, 1, 1, 0,  0,  4, 1, 1, 0, 0);  // 20 -> SFX 0
        add(0, 4, 1, 0, 0,  1,  4, 1, 1, 0, 1);  // 21 tone[0]
        add(0, 4, 1, 4, 0,  6,  4, 1, 1, 2, 0);  // 22 preempt by 2
        add(0, 4, 1, 0, 0,  4,  4, 1, 1, 2, 1);  // 23 tone[2]
        add(0, 4, 1, 2, 0,  0,  4, 1, 1, 2, 0);  // 24 lower prio dropped
        add(0, 4, 1, 4, 0,  0,  4, 1, 1, 2, 0);  // 25 equal prio dropped
        add(0, 4, 1, 0, 0,  3,  4, 1, 1, 2, 0);  // 26
        add(0, 4, 1, 0, 0,  4,  4, 1, 0, 2, 1);  // 27 back to PLAY, sel held
        add(0, 4, 1, 0, 8,  0,  4, 1, 0, 2, 1);  // 28
        add(0, 3, 0, 2, 0,  0,  2, 0, 0, 2, 0);  // 29 change + sfx: change wins
        add(0, 3, 0, 0, 0,  0,  2, 0, 0, 2, 0);  // 30
        add(0, 3, 0, 0, 0,  0,  2, 0, 0, 2, 0);  // 31
        add(0, 3, 0, 0, 0,  0,  2, 1, 0, 2, 0);  // 32 PLAY
        add(0, 3, 0, 2, 0,  0,  2, 1, 1, 1, 0);  // 33 -> SFX 1
        add(0, 1, 0, 0, 0,  2,  1, 0, 0, 1, 1);  // 34 abort to GAP intro
        add(0, 1, 0, 0, 0,  0,  1, 0, 0, 1, 0);  // 35
        add(0, 1, 0, 0, 0,  0,  1, 0, 0, 1, 0);  // 36
        add(0, 1, 0, 0, 0,  0,  1, 1, 0, 1, 0);  // 37 PLAY
        add(0, 1, 0, 1, 0,  0,  1, 1, 1, 0, 0);  // 38 -> SFX 0
        add(0, 1, 0, 0, 0,  1,  1, 1, 1, 0, 1);  // 39
        add(1, 1, 0, 0, 0,  1,  0, 0, 0, 0, 0);  // 40 reset mid-SFX
        add(0, 5, 0, 0, 15, 7,  0, 0, 0, 0, 0);  // 41 YN -> silent
        add(0, 5, 0, 7, 15, 7,  0, 0, 0, 0, 0);  // 42 sfx ignored in SILENT
        add(0, 2, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 43 personaje -> GAP
        add(0, 2, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 44
        add(1, 2, 0, 0, 0,  0,  0, 0, 0, 0, 0);  // 45 reset mid-GAP
        add(0, 2, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 46 fresh GAP
        add(0, 2, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 47
        add(0, 2, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 48
        add(0, 2, 0, 0, 0,  0,  1, 1, 0, 0, 0);  // 49 PLAY
        add(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);  // 50 PLAY -> SILENT
        add(0, 1, 0, 0, 0,  0,  1, 0, 0, 0, 0);  // 51
        add(0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);  // 52 GAP -> SILENT
        add(0, 4, 0, 0, 0,  0,  0, 0, 0, 0, 0);  // 53 GP without result
        add(0, 4, 3, 0, 0,  0,  0, 0, 0, 0, 0);  // 54 GP invalid result
        add(0, 6, 0, 0, 0,  0,  0, 0, 0, 0, 0);  // 55 undefined state

        foreach (vecs[i]) begin
            reset = vecs[i].rst; presente = vecs[i].pres; v_d = vecs[i].vd;
            sfx_req = vecs[i].req; muic = vecs[i].mu; sfx_tone = vecs[i].tone;
            e.row = i; e.trk = vecs[i].trk; e.pe = vecs[i].pe; e.se = vecs[i].se;
            e.sel = vecs[i].sel; e.mus = vecs[i].mus;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check_outputs(sb.pop_front());
        end

        // Gap length measured end to end: entry edge plus three silent edges.
        reset = 1'b0; presente = 4'd3; v_d = '0; sfx_req = '0; muic = '0; sfx_tone = '0;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!play_en && edges < 10);
        chk("gap_edges", 100, edges, 4);
        chk("gap_track", 100, int'(track_sel), 2);

        // Effect length: request edge then five SFX edges before PLAY returns.
        sfx_req = 3'b010;
        @(posedge clk);
        #1;
        sfx_req = '0;
        chk("sfx_start", 101, int'(sfx_en), 1);
        edges = 0;
        while (sfx_en && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("sfx_edges", 101, edges, 5);
        chk("sfx_hold_sel", 101, int'(sfx_sel), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_scheduler.md
AUDIO_SCHEDULER -- requirements
Module: audio_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CLK_HZ, 25000000, system clock frequency in Hz.
  GAP_MS, 50, silence gap before each new track, in ms.
  SFX_MS, 200, sound-effect duration, in ms.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk  in  1  single system clock, all logic on posedge.
  reset  in  1  synchronous, active-high reset.
  presente  in  4  game FSM state (apagado=0, hola=1, personaje=2, juego=3, GP=4, YN=5).
  v_d  in  2  game result (1=defeat, 2=victory).
  sfx_req  in  3  sound-effect request pulses; bit2 highest priority.
  muic  in  4  square-wave outputs of the four note generators (bit n = track n+1).
  sfx_tone  in  3  square-wave outputs of the effect generators (bit n = effect n).
  track_sel  out  3  selected track (0 = none, 1..4).
  play_en  out  1  enable ("estado") to all note generators; 0 restarts them.
  sfx_en  out  1  effect active.
  sfx_sel  out  2  index of the active effect.
  musica  out  1  registered audio output to the pin.

Function
REQ-003 Target track SHALL decode as: hola/personaje->1, juego->2, GP with v_d=2->3, GP with v_d=1->4, all other combinations->0.
REQ-004 The ms timebase SHALL be a cycle counter wrapping at CLK_HZ/1000-1 that emits a 1-cycle tick on wrap and restarts at 0 on every FSM state entry.
REQ-005 The FSM SHALL have the states SILENT, GAP, PLAY and SFX, sampling target, v_d and sfx_req every cycle and transitioning on the next edge.
REQ-006 In SILENT: track_sel=0 and play_en=0; a nonzero target SHALL cause entry to GAP with track_sel=target.
REQ-007 GAP SHALL hold play_en=0 for exactly GAP_MS ms of cycles and then enter PLAY.
REQ-008 In GAP, a target change to another nonzero track SHALL load the new track_sel and restart the GAP timing, and target 0 SHALL return the FSM to SILENT.
REQ-009 In PLAY, play_en SHALL be 1.
REQ-010 In PLAY, a target differing from track_sel SHALL cause entry to GAP (or to SILENT if the target is 0).
REQ-011 In PLAY, any sfx_req bit SHALL cause entry to SFX with sfx_sel = index of the highest set bit.
REQ-012 In PLAY, when a track change and sfx_req occur in the same cycle, the track change SHALL win and the request SHALL be dropped.
REQ-013 In SFX, sfx_en SHALL be 1 and play_en SHALL stay 1; after exactly SFX_MS ms the FSM SHALL return to PLAY.
REQ-014 In SFX, a request of strictly higher priority SHALL preempt (update sfx_sel, restart timing), and requests of equal or lower priority SHALL be dropped, never queued.
REQ-015 In SFX, a target change SHALL abort the effect (sfx_en=0) and take the REQ-010 path.
REQ-016 sfx_req SHALL be ignored in SILENT and GAP.
REQ-017 musica SHALL be registered with 1-cycle latency: PLAY->muic[track_sel-1], SFX->sfx_tone[sfx_sel], otherwise 0.
REQ-018 Output sfx_sel SHALL hold its last value when sfx_en=0.

Reset
REQ-019 While reset is high at a clock edge, the FSM SHALL go to SILENT, all counters to 0 and all outputs (track_sel, play_en, sfx_en, sfx_sel, musica) to 0.
REQ-020 A reset asserted mid-GAP or mid-SFX SHALL discard all pending timing.
REQ-021 After reset releases, a nonzero target SHALL restart from GAP.

Structure
REQ-022 The presente encodings, the track IDs (NONE, INTRO, GAME, WIN, LOSE) and the FSM state encodings SHALL reside in the shared game package.
REQ-023 The ms timebase SHALL be one sub-module, audio_ms_tick (inputs clk, reset, restart; output tick), reusable by other timers.

Verification (CLK_HZ=1000, GAP_MS=3, SFX_MS=5; 1 ms = 1 cycle)
REQ-024 Reset, then presente=1 at cycle 0 -> cycle 1: track_sel=1, play_en=0; cycle 4: play_en=1; musica follows muic[0] from cycle 5.
REQ-025 In PLAY track 2, presente=4 with v_d=2 -> GAP with track_sel=3, play_en low for 3 cycles; a switch to v_d=1 during the gap -> track_sel=4 and the gap restarts.
REQ-026 PLAY, sfx_req=3'b001 -> sfx_en=1, sfx_sel=0 for 5 cycles; sfx_req=3'b100 at the 2nd SFX cycle -> sfx_sel=2 and 5 more cycles; a following 3'b010 is dropped.
REQ-027 Same-cycle presente change and sfx_req=3'b010 in PLAY -> GAP entered, sfx_en stays 0.
REQ-028 reset pulsed mid-SFX -> all outputs 0 next cycle; presente=5 afterwards -> stays SILENT, musica=0.
